// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: ALU operation codes, forwarding selects and
// the iterative multiplier state encoding.
package riscv_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLL    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_SLT    = 5'd8;
    localparam logic [4:0] ALU_SLTU   = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd11;
    localparam logic [4:0] ALU_PASS_B = 5'd12;
    localparam logic [4:0] ALU_BEQ    = 5'd16;
    localparam logic [4:0] ALU_BNE    = 5'd17;
    localparam logic [4:0] ALU_BLT    = 5'd18;
    localparam logic [4:0] ALU_BGE    = 5'd19;
    localparam logic [4:0] ALU_BLTU   = 5'd20;
    localparam logic [4:0] ALU_BGEU   = 5'd21;
    localparam logic [4:0] ALU_JALR   = 5'd22;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX operands and controls into the execute stage, redirect and EX/MEM
// register outputs back out. master drives the stage, slave is the stage.
interface execute_stage_if #(parameter int width = 32);

    logic             stall_ex;
    logic             flush_ex;
    logic [width-1:0] rs1_id_ex;
    logic [width-1:0] rs2_id_ex;
    logic [width-1:0] pc_id_ex;
    logic [width-1:0] immediate_extended_id_ex;
    logic [width-1:0] pc_plus_4_id_ex;
    logic [4:0]       rd_addr_id_ex;
    logic             Reg_Write_id_ex;
    logic             Mem_Write_id_ex;
    logic             Jump_id_ex;
    logic             Branch_id_ex;
    logic             AluSrc_id_ex;
    logic [2:0]       ResultSrc_id_ex;
    logic [4:0]       Alu_Control_id_ex;
    logic [1:0]       forward_a_ex;
    logic [1:0]       forward_b_ex;
    logic [width-1:0] i_alu_result_mem;
    logic [width-1:0] i_result_wb;

    logic             pc_src_ex;
    logic [width-1:0] pc_target_ex;
    logic             mul_busy_ex;
    logic [width-1:0] alu_result_ex_mem;
    logic [width-1:0] write_data_ex_mem;
    logic [width-1:0] pc_plus_4_ex_mem;
    logic [4:0]       rd_addr_ex_mem;
    logic             Reg_Write_ex_mem;
    logic             Mem_Write_ex_mem;
    logic [2:0]       ResultSrc_ex_mem;

    modport master (
        output stall_ex, flush_ex, rs1_id_ex, rs2_id_ex, pc_id_ex,
               immediate_extended_id_ex, pc_plus_4_id_ex, rd_addr_id_ex,
               Reg_Write_id_ex, Mem_Write_id_ex, Jump_id_ex, Branch_id_ex,
               AluSrc_id_ex, ResultSrc_id_ex, Alu_Control_id_ex,
               forward_a_ex, forward_b_ex, i_alu_result_mem, i_result_wb,
        input  pc_src_ex, pc_target_ex, mul_busy_ex, alu_result_ex_mem,
               write_data_ex_mem, pc_plus_4_ex_mem, rd_addr_ex_mem,
               Reg_Write_ex_mem, Mem_Write_ex_mem, ResultSrc_ex_mem
    );

    modport slave (
        input  stall_ex, flush_ex, rs1_id_ex, rs2_id_ex, pc_id_ex,
               immediate_extended_id_ex, pc_plus_4_id_ex, rd_addr_id_ex,
               Reg_Write_id_ex, Mem_Write_id_ex, Jump_id_ex, Branch_id_ex,
               AluSrc_id_ex, ResultSrc_id_ex, Alu_Control_id_ex,
               forward_a_ex, forward_b_ex, i_alu_result_mem, i_result_wb,
        output pc_src_ex, pc_target_ex, mul_busy_ex, alu_result_ex_mem,
               write_data_ex_mem, pc_plus_4_ex_mem, rd_addr_ex_mem,
               Reg_Write_ex_mem, Mem_Write_ex_mem, ResultSrc_ex_mem
    );

endinterface

// File: rtl/execute_stage_alu_unit.sv
// Combinational ALU: arithmetic/logic results plus branch condition for the
// compare codes. Multiply is not computed here (code 11 yields 0).
module alu_unit
    import riscv_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic [4:0]       alu_control,
    output logic [width-1:0] result,
    output logic             branch_cond
);

    logic [width-1:0] sum;
    logic [width-1:0] diff;
    logic [4:0]       shamt;
    logic             eq;
    logic             lt;
    logic             ltu;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[4:0];
    assign eq    = (a == b);
    assign lt    = ($signed(a) < $signed(b));
    assign ltu   = (a < b);

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD:    result = sum;
            ALU_SUB:    result = diff;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_SLL:    result = a << shamt;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = $signed(a) >>> shamt;
            ALU_SLT:    result = {{(width-1){1'b0}}, lt};
            ALU_SLTU:   result = {{(width-1){1'b0}}, ltu};
            ALU_PASS_B: result = b;
            ALU_JALR:   result = sum;
            ALU_BEQ, ALU_BNE, ALU_BLT,
            ALU_BGE, ALU_BLTU, ALU_BGEU: result = diff;
            default:    result = '0;
        endcase
    end

    always_comb begin
        branch_cond = 1'b0;
        case (alu_control)
            ALU_BEQ:  branch_cond = eq;
            ALU_BNE:  branch_cond = !eq;
            ALU_BLT:  branch_cond = lt;
            ALU_BGE:  branch_cond = !lt;
            ALU_BLTU: branch_cond = ltu;
            ALU_BGEU: branch_cond = !ltu;
            default:  branch_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// RV32 execute stage: operand forwarding, ALU, branch/jump redirect, EX/MEM register.
// Iterative 32-step multiplier present only when EXECUTE_MUL_EN is defined.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int width = 32
) (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave ex
);

    logic [width-1:0] op_a;
    logic [width-1:0] fwd_b;
    logic [width-1:0] op_b;
    logic [width-1:0] alu_result;
    logic             branch_cond;
    logic [width-1:0] jalr_sum;
    logic             mul_busy;
    logic             mul_done;
    logic [width-1:0] product;

    always_comb begin
        op_a = ex.rs1_id_ex;
        case (ex.forward_a_ex)
            FWD_WB:  op_a = ex.i_result_wb;
            FWD_MEM: op_a = ex.i_alu_result_mem;
            default: op_a = ex.rs1_id_ex;
        endcase
    end

    always_comb begin
        fwd_b = ex.rs2_id_ex;
        case (ex.forward_b_ex)
            FWD_WB:  fwd_b = ex.i_result_wb;
            FWD_MEM: fwd_b = ex.i_alu_result_mem;
            default: fwd_b = ex.rs2_id_ex;
        endcase
    end

    assign op_b = ex.AluSrc_id_ex ? ex.immediate_extended_id_ex : fwd_b;

    alu_unit #(.width(width)) u_alu (
        .a           (op_a),
        .b           (op_b),
        .alu_control (ex.Alu_Control_id_ex),
        .result      (alu_result),
        .branch_cond (branch_cond)
    );

    // JALR target uses the immediate directly, independent of AluSrc.
    assign jalr_sum        = op_a + ex.immediate_extended_id_ex;
    assign ex.pc_src_ex    = (ex.Branch_id_ex & branch_cond) | ex.Jump_id_ex;
    assign ex.pc_target_ex = (ex.Jump_id_ex && ex.Alu_Control_id_ex == ALU_JALR)
                           ? {jalr_sum[width-1:1], 1'b0}
                           : ex.pc_id_ex + ex.immediate_extended_id_ex;

`ifdef EXECUTE_MUL_EN
    mul_state_t       state_q;
    mul_state_t       state_d;
    logic [width-1:0] mcand_q;
    logic [width-1:0] mplier_q;
    logic [width-1:0] acc_q;
    logic [4:0]       count_q;
    logic             is_mul;
    logic             mul_start;
    logic             mul_step;

    assign is_mul    = (ex.Alu_Control_id_ex == ALU_MUL);
    assign mul_start = (state_q == MUL_IDLE) && is_mul && !ex.flush_ex && !ex.stall_ex;
    assign mul_step  = (state_q == MUL_RUN) && !ex.flush_ex && !ex.stall_ex;

    always_ff @(posedge clk) begin
        if (rst) state_q <= MUL_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (mul_start) state_d = MUL_RUN;
            MUL_RUN: begin
                if (ex.flush_ex)                       state_d = MUL_IDLE;
                else if (!ex.stall_ex && count_q == 5'd31) state_d = MUL_DONE;
            end
            MUL_DONE: begin
                if (ex.flush_ex || !ex.stall_ex) state_d = MUL_IDLE;
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    // Shift-add: multiplicand walks left, multiplier walks right, low bits kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (mul_start) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (mul_step) begin
            acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 5'd1;
        end
    end

    assign mul_busy = ((state_q == MUL_IDLE) && is_mul) || (state_q == MUL_RUN);
    assign mul_done = (state_q == MUL_DONE);
    assign product  = acc_q;
`else
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign product  = '0;
`endif

    assign ex.mul_busy_ex = mul_busy;

    always_ff @(posedge clk) begin
        if (rst || ex.flush_ex) begin
            ex.alu_result_ex_mem <= '0;
            ex.write_data_ex_mem <= '0;
            ex.pc_plus_4_ex_mem  <= '0;
            ex.rd_addr_ex_mem    <= '0;
            ex.Reg_Write_ex_mem  <= 1'b0;
            ex.Mem_Write_ex_mem  <= 1'b0;
            ex.ResultSrc_ex_mem  <= '0;
        end else if (ex.stall_ex) begin
            ex.alu_result_ex_mem <= ex.alu_result_ex_mem;
            ex.write_data_ex_mem <= ex.write_data_ex_mem;
            ex.pc_plus_4_ex_mem  <= ex.pc_plus_4_ex_mem;
            ex.rd_addr_ex_mem    <= ex.rd_addr_ex_mem;
            ex.Reg_Write_ex_mem  <= ex.Reg_Write_ex_mem;
            ex.Mem_Write_ex_mem  <= ex.Mem_Write_ex_mem;
            ex.ResultSrc_ex_mem  <= ex.ResultSrc_ex_mem;
        end else if (mul_busy) begin
            ex.alu_result_ex_mem <= '0;
            ex.write_data_ex_mem <= '0;
            ex.pc_plus_4_ex_mem  <= '0;
            ex.rd_addr_ex_mem    <= '0;
            ex.Reg_Write_ex_mem  <= 1'b0;
            ex.Mem_Write_ex_mem  <= 1'b0;
            ex.ResultSrc_ex_mem  <= '0;
        end else begin
            ex.alu_result_ex_mem <= mul_done ? product : alu_result;
            ex.write_data_ex_mem <= fwd_b;
            ex.pc_plus_4_ex_mem  <= ex.pc_plus_4_id_ex;
            ex.rd_addr_ex_mem    <= ex.rd_addr_id_ex;
            ex.Reg_Write_ex_mem  <= ex.Reg_Write_id_ex;
            ex.Mem_Write_ex_mem  <= ex.Mem_Write_id_ex;
            ex.ResultSrc_ex_mem  <= ex.ResultSrc_id_ex;
        end
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage pipelined RISC-V core. It sits directly downstream of the ID/EX register and consumes its operand, address and control outputs. It selects forwarded operands, runs the ALU, resolves branches and jumps, and launches an optional iterative multiplier. Its EX/MEM pipeline register, with flush and stall, feeds the memory stage.

## Interface
- `width`, 32: datapath width.
- `clk` input 1: clock. Rising edge only.
- `rst` input 1: synchronous, active-high reset.
- `stall_ex` input 1: hold the EX/MEM register and the multiplier state.
- `flush_ex` input 1: load a bubble into EX/MEM and abort the multiplier.
- `rs1_id_ex`, `rs2_id_ex`, `pc_id_ex`, `immediate_extended_id_ex`, `pc_plus_4_id_ex` input width: operands from ID/EX.
- `rd_addr_id_ex` input 5: destination register address.
- `Reg_Write_id_ex`, `Mem_Write_id_ex`, `Jump_id_ex`, `Branch_id_ex`, `AluSrc_id_ex` input 1: control signals.
- `ResultSrc_id_ex` input 3: result source select.
- `Alu_Control_id_ex` input 5: operation code.
- `forward_a_ex`, `forward_b_ex` input 2: operand source select. 0 = register file, 1 = `i_result_wb`, 2 = `i_alu_result_mem`, 3 = register file.
- `i_alu_result_mem`, `i_result_wb` input width: forwarding sources.
- `pc_src_ex` output 1: redirect fetch. Combinational.
- `pc_target_ex` output width: redirect address. Combinational.
- `mul_busy_ex` output 1: stall request to the hazard unit. Combinational from FSM state.
- `alu_result_ex_mem`, `write_data_ex_mem`, `pc_plus_4_ex_mem` output width: registered results.
- `rd_addr_ex_mem` output 5: registered destination address.
- `Reg_Write_ex_mem`, `Mem_Write_ex_mem` output 1: registered controls.
- `ResultSrc_ex_mem` output 3: registered result source select.

## Operation
- Operand A = forwarded rs1.
- Forwarded B = forwarded rs2. Forwarded B is also the store data.
- Operand B = `immediate_extended_id_ex` if `AluSrc_id_ex`, else forwarded B.
- ALU codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[4:0].
  - 8 SLT (signed), 9 SLTU.
  - 11 MUL: low 32 bits of the product.
  - 12 PASS_B (LUI).
  - 22 JALR: result A+B.
  - 16 BEQ, 17 BNE, 18 BLT, 19 BGE, 20 BLTU, 21 BGEU: compare codes, result A−B.
  - All other codes produce 0. Arithmetic wraps modulo 2^width.
- `pc_src_ex` = (`Branch_id_ex` & compare true) | `Jump_id_ex`.
- `pc_target_ex` = (A+imm) & ~1 when `Jump_id_ex` and code 22; otherwise `pc_id_ex` + `immediate_extended_id_ex`.
- Multiplier FSM, states IDLE, RUN, DONE:
  - IDLE: on code 11 and not `flush_ex`, latch A and B, clear the accumulator, set count=0, go to RUN.
  - RUN: one shift-add step per cycle; count increments. After count 31, go to DONE.
  - DONE: hold while `stall_ex`=1; otherwise return to IDLE.
  - `mul_busy_ex`=1 in IDLE-with-MUL and in RUN.
- EX/MEM update priority:
  - `rst`: all fields 0.
  - `flush_ex`: all fields 0.
  - `stall_ex`: hold all fields.
  - `mul_busy_ex`: insert a bubble (all fields 0).
  - Otherwise capture the stage results. In DONE, `alu_result_ex_mem` takes the product.

## Timing
- Reset: every registered output is 0 and the FSM is IDLE.
- Non-MUL operation: one-cycle latency, ID/EX to EX/MEM.
- `pc_src_ex` and `pc_target_ex` are valid in the same cycle the instruction is in EX.
- MUL sequence:
  - `mul_busy_ex` is high for 33 cycles: the entry cycle plus 32 RUN cycles.
  - The DONE cycle is the 34th; EX/MEM captures the product at the end of it.
- Forwarding inputs are sampled once, at MUL entry. Later changes are ignored.
- `flush_ex`, or `rst`, in RUN or DONE returns the FSM to IDLE on the next edge and discards the product.
- `stall_ex` in RUN freezes the count and the accumulator.
- Simultaneous `flush_ex` and `stall_ex`: flush wins.

## Configuration
- `EXECUTE_MUL_EN` defined: multiplier FSM present; code 11 behaves as described above.
- `EXECUTE_MUL_EN` not defined:
  - No FSM logic; `mul_busy_ex` is tied to 0.
  - Code 11 produces result 0 with one-cycle latency.

## Structure
- The shared package `riscv_pkg` holds:
  - the ALU code constants;
  - the multiplier state enum;
  - the forwarding select constants.
- One sub-module is natural: `alu_unit`, combinational, covering results and compare flags. The FSM and EX/MEM register stay in `execute_stage`.

## Test plan
- ADD: rs1=5, rs2=7, code 0, `Reg_Write`=1, rd=3 -> next cycle `alu_result_ex_mem`=12, `rd_addr_ex_mem`=3, `Reg_Write_ex_mem`=1.
- Forwarding: `forward_a_ex`=2, `i_alu_result_mem`=0x100, imm=4, `AluSrc`=1 -> 0x104. With `forward_b_ex`=1 and `i_result_wb`=0xAB -> `write_data_ex_mem`=0xAB.
- BNE, not taken then taken:
  - rs1=rs2=9, `Branch`=1, code 17 -> `pc_src_ex`=0.
  - rs2=8, `pc_id_ex`=0x40, imm=−8 -> `pc_src_ex`=1, `pc_target_ex`=0x38.
- JALR: rs1=0x1001, imm=2, `Jump`=1, code 22 -> `pc_target_ex`=0x1002, `pc_plus_4_ex_mem` captured.
- MUL (`EXECUTE_MUL_EN`): 0xFFFFFFFF × 3 -> `mul_busy_ex` high for 33 cycles with EX/MEM bubbles, then `alu_result_ex_mem`=0xFFFFFFFD.
- Abort and reset: `flush_ex` at RUN count 10 -> FSM IDLE, EX/MEM all 0. `rst` mid-operation -> all outputs 0.
